// File: rtl/sh7034_itu_irq_arb.sv
// SH7034 ITU interrupt arbiter: samples the 15 ITU request lines, picks the
// highest-priority unmasked source and presents it to the CPU with a req/ack handshake.
module sh7034_itu_irq_arb #(
    parameter int unsigned ACK_HOLD = 2,
    parameter logic [7:0]  VEC_BASE = 8'd80
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic [4:0]  IMIA_IRQ,
    input  logic [4:0]  IMIB_IRQ,
    input  logic [4:0]  OVI_IRQ,
    input  logic [19:0] ITU_PRI,
    input  logic [3:0]  INT_MASK,
    input  logic        INT_ACK,
    output logic        INT_REQ,
    output logic [3:0]  INT_LVL,
    output logic [7:0]  INT_VEC
);

    localparam int unsigned NCH  = 5;
    localparam int unsigned NSRC = 3;
    localparam int unsigned PW   = 4;
    localparam int unsigned CHW  = 3;
    localparam int unsigned SRW  = 2;
    localparam int unsigned CNTW = 4;
    localparam int unsigned VW   = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [NCH-1:0]        r_imia, r_imib, r_ovi;
    logic [NCH*PW-1:0]     r_pri;
    logic                  r_req, w_req_nxt;
    logic [PW-1:0]         r_lvl, w_lvl_nxt;
    logic [VW-1:0]         r_vec, w_vec_nxt;
    logic [CHW-1:0]        r_ch, w_ch_nxt;
    logic [SRW-1:0]        r_src, w_src_nxt;
    logic [CNTW-1:0]       r_cnt, w_cnt_nxt;

    logic [NCH-1:0]            w_ch_en;
    logic [NSRC-1:0][NCH-1:0]  w_cand;
    logic                      w_any;
    logic [PW-1:0]             w_lvl;
    logic [CHW-1:0]            w_ch;
    logic [SRW-1:0]            w_src;
    logic [VW-1:0]             w_vec;
    logic                      w_pres_ok;

    // A channel competes only when enabled and above the CPU mask
    always_comb begin
        w_ch_en = '0;
        for (int ch = 0; ch < int'(NCH); ch++) begin
            w_ch_en[ch] = (r_pri[PW*ch +: PW] != '0) && (r_pri[PW*ch +: PW] > INT_MASK);
        end
    end

    assign w_cand[0] = r_imia & w_ch_en;
    assign w_cand[1] = r_imib & w_ch_en;
    assign w_cand[2] = r_ovi  & w_ch_en;

    // Scan order (channel ascending, IMIA/IMIB/OVI) with strict '>' resolves ties
    always_comb begin
        w_any = 1'b0;
        w_lvl = '0;
        w_ch  = '0;
        w_src = '0;
        for (int ch = 0; ch < int'(NCH); ch++) begin
            for (int src = 0; src < int'(NSRC); src++) begin
                if (w_cand[src][ch] && (r_pri[PW*ch +: PW] > w_lvl)) begin
                    w_any = 1'b1;
                    w_lvl = r_pri[PW*ch +: PW];
                    w_ch  = CHW'(ch);
                    w_src = SRW'(src);
                end
            end
        end
    end

    assign w_vec     = VW'(VEC_BASE + VW'({w_ch, 2'b00}) + VW'(w_src));
    assign w_pres_ok = w_cand[r_src][r_ch];

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_lvl_nxt   = r_lvl;
        w_vec_nxt   = r_vec;
        w_ch_nxt    = r_ch;
        w_src_nxt   = r_src;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_req_nxt   = 1'b1;
                    w_lvl_nxt   = w_lvl;
                    w_vec_nxt   = w_vec;
                    w_ch_nxt    = w_ch;
                    w_src_nxt   = w_src;
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (INT_ACK) begin
                    w_req_nxt   = 1'b0;
                    w_cnt_nxt   = CNTW'(ACK_HOLD);
                    w_state_nxt = S_HOLD;
                end else if (!w_pres_ok) begin
                    if (w_any) begin
                        w_lvl_nxt = w_lvl;
                        w_vec_nxt = w_vec;
                        w_ch_nxt  = w_ch;
                        w_src_nxt = w_src;
                    end else begin
                        w_req_nxt   = 1'b0;
                        w_lvl_nxt   = '0;
                        w_vec_nxt   = '0;
                        w_ch_nxt    = '0;
                        w_src_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_lvl > r_lvl) begin
                    w_lvl_nxt = w_lvl;
                    w_vec_nxt = w_vec;
                    w_ch_nxt  = w_ch;
                    w_src_nxt = w_src;
                end
            end
            S_HOLD: begin
                if (r_cnt <= CNTW'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNTW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sample stage and arbiter state; everything advances only on CE_R
    always_ff @(posedge CLK) begin
        if (CE_R) begin
            if (RST) begin
                r_state <= S_IDLE;
                r_imia  <= '0;
                r_imib  <= '0;
                r_ovi   <= '0;
                r_pri   <= '0;
                r_req   <= 1'b0;
                r_lvl   <= '0;
                r_vec   <= '0;
                r_ch    <= '0;
                r_src   <= '0;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_imia  <= IMIA_IRQ;
                r_imib  <= IMIB_IRQ;
                r_ovi   <= OVI_IRQ;
                r_pri   <= ITU_PRI;
                r_req   <= w_req_nxt;
                r_lvl   <= w_lvl_nxt;
                r_vec   <= w_vec_nxt;
                r_ch    <= w_ch_nxt;
                r_src   <= w_src_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end
    end

    assign INT_REQ = r_req;
    assign INT_LVL = r_lvl;
    assign INT_VEC = r_vec;

endmodule
